branch_resolve_unit: RTL and testbench

- Sits between the branch functional unit and the backend speculation state: allocates branch tags at dispatch and tracks which tags are live.
- Turns branch-FU resolutions into the registered BRB broadcast (clean/kill) that the COB, reservation stations and ROB consume.
- On a mispredict, reads the COB checkpoint for the resolving tag and drives RAT restore, free-list read-pointer restore and frontend redirect.

---
 rtl/backend_types.sv | 38 +++
 rtl/brb_itf.sv | 11 +
 rtl/branch_tag_tracker.sv | 54 +++++
 rtl/branch_resolve_unit.sv | 107 ++++++++++
 tb/tb_branch_resolve_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/backend_types.sv
// Shared backend speculation types: COB checkpoint layout, RAT entries,
// BRB broadcast payload and the branch-resolve FSM states.
package backend_types;

    localparam int COB_DEPTH            = 4;
    localparam int COB_ADDR_WIDTH       = $clog2(COB_DEPTH);
    localparam int NUM_ARCH_REGISTERS   = 32;
    localparam int FREE_LIST_ADDR_WIDTH = 5;
    localparam int PHYS_REG_WIDTH       = FREE_LIST_ADDR_WIDTH + 1;

    typedef logic [PHYS_REG_WIDTH-1:0]       rat_entry_t;
    typedef logic [FREE_LIST_ADDR_WIDTH:0]   free_ptr_t;
    typedef logic [COB_ADDR_WIDTH-1:0]       br_tag_t;
    typedef logic [COB_DEPTH-1:0]            br_mask_t;

    typedef struct packed {
        rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat;
        free_ptr_t                           free_rptr;
    } cob_entry_t;

    typedef struct packed {
        logic    broadcast;
        br_tag_t tag;
        logic    clean;
        logic    kill;
    } brb_req_t;

    typedef enum logic [1:0] {
        IDLE,
        KILL,
        RECOVER
    } brb_state_t;

    function automatic br_mask_t tag_onehot(input br_tag_t tag);
        return br_mask_t'(1) << tag;
    endfunction

endpackage

// File: rtl/brb_itf.sv
// Branch resolution broadcast bus consumed by the COB, reservation stations
// and ROB.
interface brb_itf;
    import backend_types::*;

    brb_req_t req;

    modport master (output req);
    modport slave  (input  req);

endinterface

// File: rtl/branch_tag_tracker.sv
// Live-branch mask plus per-tag dependency matrix; dep_mask[t] records the
// branches that were already in flight when tag t was allocated.
module branch_tag_tracker
    import backend_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     alloc_en,
    input  br_tag_t  alloc_tag,
    input  logic     clean_en,
    input  logic     kill_en,
    input  br_tag_t  res_tag,
    output br_mask_t live_mask
);

    br_mask_t [COB_DEPTH-1:0] dep_mask;
    br_mask_t                 remove_mask;
    br_mask_t                 live_next;
    logic                     alloc_keep;

    // A kill squashes every branch younger than the resolving one, and a
    // dispatch in the kill cycle is itself younger, so it never takes effect.
    always_comb begin
        remove_mask = '0;
        alloc_keep  = alloc_en && !kill_en;
        if (clean_en) begin
            remove_mask = tag_onehot(res_tag);
        end else if (kill_en) begin
            remove_mask = tag_onehot(res_tag);
            for (int t = 0; t < COB_DEPTH; t++) begin
                if (dep_mask[t][res_tag]) remove_mask[t] = 1'b1;
            end
        end
        live_next = live_mask & ~remove_mask;
        if (alloc_keep) live_next[alloc_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_mask <= '0;
            dep_mask  <= '0;
        end else begin
            live_mask <= live_next;
            for (int t = 0; t < COB_DEPTH; t++) begin
                dep_mask[t] <= dep_mask[t] & ~remove_mask;
            end
            if (alloc_keep) dep_mask[alloc_tag] <= live_mask & ~remove_mask;
        end
    end

    a_alloc_not_live: assert property (@(posedge clk) disable iff (rst)
        alloc_en |-> !live_mask[alloc_tag]);

endmodule

// File: rtl/branch_resolve_unit.sv
// Turns branch-FU resolutions into the registered BRB clean/kill broadcast and,
// on a mispredict, drives RAT / free-list restore and the frontend redirect.
module branch_resolve_unit
    import backend_types::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                alloc_req,
    input  br_tag_t                             alloc_tag,
    output br_mask_t                            cur_mask,
    input  logic                                res_valid,
    output logic                                res_ready,
    input  br_tag_t                             res_tag,
    input  logic                                res_mispredict,
    input  logic [31:0]                         res_target,
    input  cob_entry_t                          cob_data [COB_DEPTH],
    brb_itf.master                              brif,
    output logic                                rat_restore,
    output rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_restore_data,
    output free_ptr_t                           free_rptr_restore,
    output logic                                redirect_valid,
    output logic [31:0]                         redirect_pc,
    output logic                                stall
);

    brb_state_t state, state_next;
    br_mask_t   live_mask;
    logic       accept, accept_clean, accept_kill;
    cob_entry_t cob_sel;

    brb_req_t                            brb_req_p1;
    logic                                rat_restore_p1;
    rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_data_p1;
    free_ptr_t                           free_rptr_p1;
    logic                                redirect_valid_p1;
    logic [31:0]                         redirect_pc_p1;

    // Stage p0: accept resolution; only live tags produce any effect
    assign res_ready    = (state == IDLE);
    assign accept       = res_valid && res_ready && live_mask[res_tag];
    assign accept_clean = accept && !res_mispredict;
    assign accept_kill  = accept && res_mispredict;
    assign cob_sel      = cob_data[res_tag];
    assign cur_mask     = live_mask;

    branch_tag_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_req),
        .alloc_tag (alloc_tag),
        .clean_en  (accept_clean),
        .kill_en   (accept_kill),
        .res_tag   (res_tag),
        .live_mask (live_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE:    if (accept_kill) state_next = KILL;
            KILL:    begin stall = 1'b1; state_next = RECOVER; end
            RECOVER: begin stall = 1'b1; state_next = IDLE;    end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: registered broadcast, restore and redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            brb_req_p1        <= '0;
            rat_restore_p1    <= 1'b0;
            rat_data_p1       <= '0;
            free_rptr_p1      <= '0;
            redirect_valid_p1 <= 1'b0;
            redirect_pc_p1    <= '0;
        end else begin
            brb_req_p1.broadcast <= accept;
            brb_req_p1.clean     <= accept_clean;
            brb_req_p1.kill      <= accept_kill;
            rat_restore_p1       <= accept_kill;
            redirect_valid_p1    <= accept_kill;
            if (accept) brb_req_p1.tag <= res_tag;
            if (accept_kill) begin
                rat_data_p1    <= cob_sel.rat;
                free_rptr_p1   <= cob_sel.free_rptr;
                redirect_pc_p1 <= res_target;
            end
        end
    end

    assign brif.req          = brb_req_p1;
    assign rat_restore       = rat_restore_p1;
    assign rat_restore_data  = rat_data_p1;
    assign free_rptr_restore = free_rptr_p1;
    assign redirect_valid    = redirect_valid_p1;
    assign redirect_pc       = redirect_pc_p1;

    a_alloc_not_resolving: assert property (@(posedge clk) disable iff (rst)
        (accept && alloc_req) |-> (alloc_tag != res_tag));

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: allocation, clean, kill, same-cycle
// alloc/resolve interactions, non-live resolution and reset during recovery.
module tb_branch_resolve_unit;
    import backend_types::*;

    logic                                clk = 1'b0;
    logic                                rst = 1'b1;
    logic                                alloc_req = 1'b0;
    br_tag_t                             alloc_tag = '0;
    br_mask_t                            cur_mask;
    logic                                res_valid = 1'b0;
    logic                                res_ready;
    br_tag_t                             res_tag = '0;
    logic                                res_mispredict = 1'b0;
    logic [31:0]                         res_target = '0;
    cob_entry_t                          cob_data [COB_DEPTH];
    logic                                rat_restore;
    rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_restore_data;
    free_ptr_t                           free_rptr_restore;
    logic                                redirect_valid;
    logic [31:0]                         redirect_pc;
    logic                                stall;

    int checks = 0;
    int errors = 0;

    brb_itf brif ();

    branch_resolve_unit dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_req         (alloc_req),
        .alloc_tag         (alloc_tag),
        .cur_mask          (cur_mask),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_tag           (res_tag),
        .res_mispredict    (res_mispredict),
        .res_target        (res_target),
        .cob_data          (cob_data),
        .brif              (brif),
        .rat_restore       (rat_restore),
        .rat_restore_data  (rat_restore_data),
        .free_rptr_restore (free_rptr_restore),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall             (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; alloc_req = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input int tag);
        alloc_req = 1'b1; alloc_tag = br_tag_t'(tag);
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic resolve(input int tag, input logic mis, input logic [31:0] tgt);
        res_valid = 1'b1; res_tag = br_tag_t'(tag); res_mispredict = mis; res_target = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cur_mask !== 4'b0000) begin errors++; $display("FAIL reset_cur_mask got=%b exp=0000", cur_mask); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got=%b exp=1", res_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (brif.req !== '0) begin errors++; $display("FAIL reset_brb got=%h exp=0", brif.req); end
        checks++; if ({rat_restore, redirect_valid} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {rat_restore, redirect_valid}); end
        checks++; if (redirect_pc !== 32'h0 || free_rptr_restore !== '0) begin errors++; $display("FAIL reset_data pc=%h rptr=%h exp=0", redirect_pc, free_rptr_restore); end
    endtask

    task automatic test_alloc();
        do_reset();
        alloc(0);
        checks++; if (cur_mask !== 4'b0001) begin errors++; $display("FAIL alloc0_mask got=%b exp=0001", cur_mask); end
        alloc(1);
        checks++; if (cur_mask !== 4'b0011) begin errors++; $display("FAIL alloc1_mask got=%b exp=0011", cur_mask); end
        alloc(2);
        checks++; if (cur_mask !== 4'b0111) begin errors++; $display("FAIL alloc2_mask got=%b exp=0111", cur_mask); end
        checks++; if (dut.u_tracker.dep_mask[2] !== 4'b0011) begin errors++; $display("FAIL alloc_dep2 got=%b exp=0011", dut.u_tracker.dep_mask[2]); end
        checks++; if (dut.u_tracker.dep_mask[1] !== 4'b0001) begin errors++; $display("FAIL alloc_dep1 got=%b exp=0001", dut.u_tracker.dep_mask[1]); end
    endtask

    // Continues from test_alloc: tags 0,1,2 live.
    task automatic test_clean();
        resolve(1, 1'b0, 32'h0);
        tick();
        res_valid = 1'b0;
        checks++; if (brif.req !== {1'b1, 2'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL clean_brb got=%h exp=%h", brif.req, {1'b1, 2'd1, 1'b1, 1'b0}); end
        checks++; if ({stall, rat_restore, redirect_valid} !== 3'b000) begin errors++; $display("FAIL clean_no_kill got=%b exp=000", {stall, rat_restore, redirect_valid}); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL clean_ready got=%b exp=1", res_ready); end
        tick();
        checks++; if (brif.req.broadcast !== 1'b0) begin errors++; $display("FAIL clean_pulse_width got=%b exp=0", brif.req.broadcast); end
        checks++; if (cur_mask !== 4'b0101) begin errors++; $display("FAIL clean_mask got=%b exp=0101", cur_mask); end
        checks++; if (dut.u_tracker.dep_mask[2] !== 4'b0001) begin errors++; $display("FAIL clean_dep2 got=%b exp=0001", dut.u_tracker.dep_mask[2]); end
    endtask

    task automatic test_kill();
        do_reset();
        alloc(0); alloc(1); alloc(2);
        resolve(0, 1'b1, 32'h6000_0040);
        tick();
        res_valid = 1'b0;
        checks++; if (brif.req !== {1'b1, 2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL kill_brb got=%h exp=%h", brif.req, {1'b1, 2'd0, 1'b0, 1'b1}); end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h6000_0040) begin errors++; $display("FAIL kill_redirect got=%b/%h exp=1/60000040", redirect_valid, redirect_pc); end
        checks++; if (rat_restore !== 1'b1) begin errors++; $display("FAIL kill_rat_restore got=%b exp=1", rat_restore); end
        checks++; if (free_rptr_restore !== cob_data[0].free_rptr) begin errors++; $display("FAIL kill_free_rptr got=%h exp=%h", free_rptr_restore, cob_data[0].free_rptr); end
        checks++; if (rat_restore_data !== cob_data[0].rat) begin errors++; $display("FAIL kill_rat_data got=%h exp=%h", rat_restore_data, cob_data[0].rat); end
        checks++; if (cur_mask !== 4'b0000) begin errors++; $display("FAIL kill_mask got=%b exp=0000", cur_mask); end
        checks++; if (stall !== 1'b1 || res_ready !== 1'b0) begin errors++; $display("FAIL kill_n1_stall got=%b/%b exp=1/0", stall, res_ready); end
        tick();
        checks++; if (stall !== 1'b1 || res_ready !== 1'b0) begin errors++; $display("FAIL kill_n2_stall got=%b/%b exp=1/0", stall, res_ready); end
        checks++; if ({brif.req.broadcast, rat_restore, redirect_valid} !== 3'b000) begin errors++; $display("FAIL kill_pulse_width got=%b exp=000", {brif.req.broadcast, rat_restore, redirect_valid}); end
        tick();
        checks++; if (stall !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL kill_n3_idle got=%b/%b exp=0/1", stall, res_ready); end
    endtask

    task automatic test_alloc_with_kill();
        do_reset();
        alloc(0);
        resolve(0, 1'b1, 32'h1234_5678);
        alloc_req = 1'b1; alloc_tag = 2'd3;
        tick();
        alloc_req = 1'b0; res_valid = 1'b0;
        checks++; if (cur_mask !== 4'b0000) begin errors++; $display("FAIL alloc_kill_mask got=%b exp=0000", cur_mask); end
        checks++; if (redirect_pc !== 32'h1234_5678) begin errors++; $display("FAIL alloc_kill_pc got=%h exp=12345678", redirect_pc); end
        tick(); tick();
    endtask

    task automatic test_alloc_with_clean();
        do_reset();
        alloc(0); alloc(1);
        resolve(0, 1'b0, 32'h0);
        alloc_req = 1'b1; alloc_tag = 2'd3;
        tick();
        alloc_req = 1'b0; res_valid = 1'b0;
        checks++; if (cur_mask !== 4'b1010) begin errors++; $display("FAIL alloc_clean_mask got=%b exp=1010", cur_mask); end
        checks++; if (dut.u_tracker.dep_mask[3] !== 4'b0010) begin errors++; $display("FAIL alloc_clean_dep3 got=%b exp=0010", dut.u_tracker.dep_mask[3]); end
        // Tag 3 depends on tag 1, so killing 1 must also retire 3.
        resolve(1, 1'b1, 32'h0000_0100);
        tick();
        res_valid = 1'b0;
        checks++; if (cur_mask !== 4'b0000) begin errors++; $display("FAIL dep_kill_mask got=%b exp=0000", cur_mask); end
        tick(); tick();
    endtask

    task automatic test_nonlive();
        do_reset();
        alloc(0);
        resolve(2, 1'b1, 32'hDEAD_0000);
        tick();
        res_valid = 1'b0;
        checks++; if (brif.req.broadcast !== 1'b0) begin errors++; $display("FAIL nonlive_brb got=%b exp=0", brif.req.broadcast); end
        checks++; if ({stall, redirect_valid, rat_restore} !== 3'b000) begin errors++; $display("FAIL nonlive_pulses got=%b exp=000", {stall, redirect_valid, rat_restore}); end
        checks++; if (res_ready !== 1'b1 || cur_mask !== 4'b0001) begin errors++; $display("FAIL nonlive_state got=%b/%b exp=1/0001", res_ready, cur_mask); end
    endtask

    task automatic test_rst_in_recover();
        do_reset();
        alloc(0); alloc(1);
        resolve(1, 1'b1, 32'h0000_0200);
        tick();
        res_valid = 1'b0;
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL recover_stall got=%b exp=1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (stall !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL rst_recover_ctrl got=%b/%b exp=0/1", stall, res_ready); end
        checks++; if (cur_mask !== 4'b0000) begin errors++; $display("FAIL rst_recover_mask got=%b exp=0000", cur_mask); end
        checks++; if ({brif.req.broadcast, rat_restore, redirect_valid} !== 3'b000) begin errors++; $display("FAIL rst_recover_pulses got=%b exp=000", {brif.req.broadcast, rat_restore, redirect_valid}); end
    endtask

    initial begin
        for (int t = 0; t < COB_DEPTH; t++) begin
            for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
                cob_data[t].rat[i] = rat_entry_t'(t * 8 + i + 1);
            end
            cob_data[t].free_rptr = free_ptr_t'(16 + 3 * t + 1);
        end
        test_reset();
        test_alloc();
        test_clean();
        test_kill();
        test_alloc_with_kill();
        test_alloc_with_clean();
        test_nonlive();
        test_rst_in_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
